// File: rtl/score_if.sv
// Two-team scoreboard bus: pushbutton events in, BCD scores and game status out.
interface score_if;
  logic       a_up_i;
  logic       a_down_i;
  logic       b_up_i;
  logic       b_down_i;
  logic       clear_i;
  logic [3:0] score_a_tens_o;
  logic [3:0] score_a_ones_o;
  logic [3:0] score_b_tens_o;
  logic [3:0] score_b_ones_o;
  logic       game_over_o;
  logic [1:0] winner_o;
  logic       update_o;

  // Upstream side: button processors / game control
  modport master (
    output a_up_i, a_down_i, b_up_i, b_down_i, clear_i,
    input  score_a_tens_o, score_a_ones_o, score_b_tens_o, score_b_ones_o,
    input  game_over_o, winner_o, update_o
  );

  // Score keeper side
  modport slave (
    input  a_up_i, a_down_i, b_up_i, b_down_i, clear_i,
    output score_a_tens_o, score_a_ones_o, score_b_tens_o, score_b_ones_o,
    output game_over_o, winner_o, update_o
  );
endinterface

// File: rtl/score_keeper.sv
// Two-team saturating BCD score register with win detection and change flag.
module score_keeper #(
  parameter int unsigned MAX_SCORE = 99,
  parameter int unsigned WIN_SCORE = 21
) (
  input  logic    clk_1khz,
  input  logic    rst_i,
  score_if.slave  sk
);

  localparam int unsigned VAL_W = 7;

  typedef enum logic {PLAYING, GAME_OVER} state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       hist;          // {a_up, a_down, b_up, b_down} previous values
  logic [7:0]       score_a;       // {tens, ones}
  logic [7:0]       score_b;
  logic [7:0]       next_a;
  logic [7:0]       next_b;
  logic [1:0]       winner;
  logic [1:0]       next_winner;
  logic             update;
  logic             up_ok;
  logic             ev_au, ev_ad, ev_bu, ev_bd;
  logic             win_a, win_b;

  function automatic logic [VAL_W-1:0] bcd_value(input logic [7:0] s);
    return VAL_W'(s[7:4]) * VAL_W'(10) + VAL_W'(s[3:0]);
  endfunction

  // One BCD step; simultaneous up/down cancels, both ends saturate
  function automatic logic [7:0] bcd_step(input logic [7:0] s, input logic up, input logic dn);
    logic [VAL_W-1:0] v;
    logic [7:0]       r;
    v = bcd_value(s);
    r = s;
    if (up && !dn && (v < VAL_W'(MAX_SCORE))) begin
      if (s[3:0] == 4'd9) r = {s[7:4] + 4'd1, 4'd0};
      else                r = {s[7:4], s[3:0] + 4'd1};
    end else if (dn && !up && (v != VAL_W'(0))) begin
      if (s[3:0] == 4'd0) r = {s[7:4] - 4'd1, 4'd9};
      else                r = {s[7:4], s[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Rising-edge events, next scores and next game status
  always_comb begin
    up_ok       = (state == PLAYING);
    ev_au       = sk.a_up_i   & ~hist[3] & up_ok;
    ev_ad       = sk.a_down_i & ~hist[2];
    ev_bu       = sk.b_up_i   & ~hist[1] & up_ok;
    ev_bd       = sk.b_down_i & ~hist[0];
    next_a      = bcd_step(score_a, ev_au, ev_ad);
    next_b      = bcd_step(score_b, ev_bu, ev_bd);
    win_a       = (bcd_value(next_a) >= VAL_W'(WIN_SCORE));
    win_b       = (bcd_value(next_b) >= VAL_W'(WIN_SCORE));
    next_state  = state;
    next_winner = winner;
    case (state)
      PLAYING: begin
        if (win_a || win_b) begin
          next_state  = GAME_OVER;
          next_winner = {win_b, win_a};
        end
      end
      GAME_OVER: begin
        if (!win_a && !win_b) begin
          next_state  = PLAYING;
          next_winner = 2'b00;
        end else begin
          next_winner = {win_b, win_a};
        end
      end
      default: begin
        next_state  = PLAYING;
        next_winner = 2'b00;
      end
    endcase
  end

  // State, scores, history and status registers; reset beats clear beats events
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      state   <= PLAYING;
      hist    <= 4'b0000;
      score_a <= 8'h00;
      score_b <= 8'h00;
      winner  <= 2'b00;
      update  <= 1'b0;
    end else begin
      hist <= {sk.a_up_i, sk.a_down_i, sk.b_up_i, sk.b_down_i};
      if (sk.clear_i) begin
        state   <= PLAYING;
        score_a <= 8'h00;
        score_b <= 8'h00;
        winner  <= 2'b00;
        update  <= 1'b0;
      end else begin
        state   <= next_state;
        score_a <= next_a;
        score_b <= next_b;
        winner  <= next_winner;
        update  <= (next_a != score_a) || (next_b != score_b);
      end
    end
  end

  assign sk.score_a_tens_o = score_a[7:4];
  assign sk.score_a_ones_o = score_a[3:0];
  assign sk.score_b_tens_o = score_b[7:4];
  assign sk.score_b_ones_o = score_b[3:0];
  assign sk.game_over_o    = (state == GAME_OVER);
  assign sk.winner_o       = winner;
  assign sk.update_o       = update;

endmodule
